// File: rtl/bandit_pkg.sv
// Shared types and constants for the bandit environment and its LFSR.
package bandit_pkg;

    localparam int ACTION_WIDTH = 8;
    localparam int REWARD_WIDTH = 8;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAW    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    // One right-shifting Galois step: the bit shifted out selects the tap mask.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/bandit_env_lfsr16.sv
// Free-running 16-bit Galois LFSR. Reusable as an exploration noise source.
// SEED must be nonzero or the register locks up at zero.
module lfsr16
    import bandit_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [15:0] q
);

    // Advance once per clock whenever out of reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/bandit_env.sv
// Multi-armed bandit environment: accepts an arm index, draws a Bernoulli
// outcome against that arm's threshold, returns it as a reward.
// Optional macro BANDIT_ENV_STATS_EN adds saturating pulls/hits counters.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high; valid must not depend on ready, and the offered data is held
// stable while valid is high and ready is low.
module bandit_env
    import bandit_pkg::*;
#(
    parameter int                      ARMS        = 4,
    parameter logic [8*ARMS-1:0]       PROBS       = {8'd200, 8'd150, 8'd100, 8'd50},
    parameter logic [15:0]             SEED        = 16'hACE1,
    parameter logic [REWARD_WIDTH-1:0] REWARD_HIT  = 8'd1,
    parameter logic [REWARD_WIDTH-1:0] REWARD_MISS = 8'd0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    action_valid,
    input  logic [ACTION_WIDTH-1:0] action_data,
    output logic                    action_ready,
    output logic                    reward_valid,
    output logic [REWARD_WIDTH-1:0] reward_data,
    input  logic                    reward_ready,
    output logic                    invalid,
`ifdef BANDIT_ENV_STATS_EN
    output logic [15:0]             pulls,
    output logic [15:0]             hits,
`endif
    output logic [15:0]             lfsr,
    output state_t                  fsm_state
);

    localparam logic [ACTION_WIDTH-1:0] ARMS_W = ACTION_WIDTH'(ARMS);

    state_t                  state_q;
    state_t                  state_d;
    logic                    accept;
    logic [ACTION_WIDTH-1:0] arm_q;
    logic [7:0]              threshold;
    logic                    arm_valid;
    logic                    hit;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clock   (clock),
        .reset_n (reset_n),
        .q       (lfsr)
    );

    assign fsm_state = state_q;

    // State register; async reset drops reward_valid immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; nothing is buffered outside IDLE.
    always_comb begin
        state_d      = state_q;
        action_ready = 1'b0;
        reward_valid = 1'b0;
        accept       = 1'b0;
        case (state_q)
            IDLE: begin
                action_ready = reset_n;
                if (action_valid && reset_n) begin
                    accept  = 1'b1;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                state_d = RESPOND;
            end
            RESPOND: begin
                reward_valid = 1'b1;
                if (reward_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Threshold mux over the configured arms; out-of-range arms see zero.
    always_comb begin
        threshold = 8'd0;
        for (int i = 0; i < ARMS; i++) begin
            if (arm_q == ACTION_WIDTH'(i)) begin
                threshold = PROBS[8*i +: 8];
            end
        end
    end

    assign arm_valid = (arm_q < ARMS_W);
    assign hit       = arm_valid && (lfsr[7:0] < threshold);

    // Datapath: latch the arm on accept, flag invalid next cycle, register outcome in DRAW.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            arm_q       <= '0;
            reward_data <= REWARD_MISS;
            invalid     <= 1'b0;
        end else begin
            invalid <= accept && (action_data >= ARMS_W);
            if (accept) begin
                arm_q <= action_data;
            end
            if (state_q == DRAW) begin
                reward_data <= hit ? REWARD_HIT : REWARD_MISS;
            end
        end
    end

`ifdef BANDIT_ENV_STATS_EN
    logic hit_q;

    // Saturating counters, stepped on each reward handshake.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_q <= 1'b0;
            pulls <= 16'd0;
            hits  <= 16'd0;
        end else begin
            if (state_q == DRAW) begin
                hit_q <= hit;
            end
            if (reward_valid && reward_ready) begin
                if (pulls != 16'hFFFF) begin
                    pulls <= pulls + 16'd1;
                end
                if (hit_q && (hits != 16'hFFFF)) begin
                    hits <= hits + 16'd1;
                end
            end
        end
    end
`endif

endmodule
